// File: rtl/avalon_pio_bidir.sv
// avalon_pio_bidir: Avalon-MM bidirectional PIO with atomic set/clear, synchronised inputs,
// per-bit edge capture gated by a post-reset warm-up, and a maskable edge- or level-based irq.
module avalon_pio_bidir #(
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int EDGE_TYPE = 0,
    parameter int IRQ_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe,
    output logic                  irq
);
    logic [DATA_WIDTH-1:0] data_out, direction, irqmask, edgecapture, s1, in_sync, prev, wd, edges, rd;
    logic [1:0] warm;
    logic wr, unused_bits;
    assign wr = chipselect & ~write_n;
    assign wd = writedata[DATA_WIDTH-1:0];
    assign unused_bits = ^writedata;
    assign edges = EDGE_TYPE == 0 ? in_sync & ~prev : EDGE_TYPE == 1 ? ~in_sync & prev : in_sync ^ prev;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= RESET_VALUE;
            direction   <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            s1          <= '0;
            in_sync     <= '0;
            prev        <= '0;
            warm        <= '0;
        end else begin
            s1      <= in_port;
            in_sync <= s1;
            prev    <= in_sync;
            warm    <= warm + 2'(warm != 2'd3);
            if (wr && address == 3'd0) data_out <= wd;
            else if (wr && address == 3'd4) data_out <= data_out | wd;
            else if (wr && address == 3'd5) data_out <= data_out & ~wd;
            if (wr && address == 3'd1) direction <= wd;
            if (wr && address == 3'd2) irqmask <= wd;
            // a new edge overrides a simultaneous write-1-to-clear
            edgecapture <= (edgecapture & ~((wr && address == 3'd3) ? wd : '0)) | ((warm == 2'd3) ? edges : '0);
        end
    end
    always_comb begin
        rd = address == 3'd0 ? in_sync :
             address == 3'd1 ? direction :
             address == 3'd2 ? irqmask :
             address == 3'd3 ? edgecapture : '0;
        readdata = 32'(rd);
    end
    assign out_port = data_out;
    assign oe = direction;
    assign irq = IRQ_MODE == 1 ? |(in_sync & irqmask) : |(edgecapture & irqmask);
endmodule

// File: tb/tb_avalon_pio_bidir.sv
// tb_avalon_pio_bidir: directed and randomized checks of two PIO variants against a history-based model.
module tb_avalon_pio_bidir;
    localparam int W = 8;
    logic clk = 0, reset_n = 0;
    logic [2:0] address = 0;
    logic chipselect = 0, write_n = 1;
    logic [31:0] writedata = 0;
    logic [W-1:0] in_port = 0;
    logic [31:0] rd[2];
    logic [W-1:0] op[2], oev[2];
    logic irqv[2];
    int passed = 0, total = 0, fails = 0;
    logic [W-1:0] m_dout[2], m_dir[2], m_mask[2], m_ec[2];
    logic [W-1:0] hist[$];
    int nedge;

    always #5 clk = ~clk;

    avalon_pio_bidir #(.DATA_WIDTH(W), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .IRQ_MODE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[0]), .in_port(in_port), .out_port(op[0]), .oe(oev[0]), .irq(irqv[0]));
    avalon_pio_bidir #(.DATA_WIDTH(W), .RESET_VALUE(8'h5A), .EDGE_TYPE(2), .IRQ_MODE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd[1]), .in_port(in_port), .out_port(op[1]), .oe(oev[1]), .irq(irqv[1]));

    function automatic logic [W-1:0] rv(int i);
        return i == 0 ? 8'hA5 : 8'h5A;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dout[i] = rv(i); m_dir[i] = 0; m_mask[i] = 0; m_ec[i] = 0;
        end
        hist = '{0, 0, 0};
        nedge = 0;
    endtask

    // hist[0] = pin sampled last edge, hist[1] = visible input, hist[2] = its predecessor
    task automatic model_edge();
        logic [W-1:0] wd, cur, old, ev;
        wd = writedata[W-1:0];
        cur = hist[1];
        old = hist[2];
        nedge++;
        for (int i = 0; i < 2; i++) begin
            ev = (i == 0) ? (cur & ~old) : (cur ^ old);
            if (chipselect && !write_n) begin
                if (address == 0) m_dout[i] = wd;
                if (address == 1) m_dir[i] = wd;
                if (address == 2) m_mask[i] = wd;
                if (address == 3) m_ec[i] = m_ec[i] & ~wd;
                if (address == 4) m_dout[i] = m_dout[i] | wd;
                if (address == 5) m_dout[i] = m_dout[i] & ~wd;
            end
            if (nedge >= 4) m_ec[i] = m_ec[i] | ev;
        end
        hist.push_front(in_port);
        void'(hist.pop_back());
    endtask

    function automatic logic [31:0] exp_rd(int i);
        case (address)
            3'd0: return 32'(hist[1]);
            3'd1: return 32'(m_dir[i]);
            3'd2: return 32'(m_mask[i]);
            3'd3: return 32'(m_ec[i]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_irq(int i);
        return i == 0 ? |(m_ec[0] & m_mask[0]) : |(hist[1] & m_mask[1]);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_rd%0d_a%0d", tag, i, address), rd[i], exp_rd(i));
            chk($sformatf("%s_out%0d", tag, i), 32'(op[i]), 32'(m_dout[i]));
            chk($sformatf("%s_oe%0d", tag, i), 32'(oev[i]), 32'(m_dir[i]));
            chk($sformatf("%s_irq%0d", tag, i), 32'(irqv[i]), 32'(exp_irq(i)));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d);
        address = a; chipselect = 1; write_n = 0; writedata = d;
        cyc();
        chipselect = 0; write_n = 1;
    endtask

    task automatic do_reset();
        reset_n = 0; chipselect = 0; write_n = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_out", 32'(op[0]), 32'hA5);
        chk("rst_oe", 32'(oev[0]), 32'h0);
        chk("rst_irq", 32'(irqv[0]), 32'h0);
        for (int a = 1; a <= 3; a++) begin
            address = 3'(a); chipselect = 1;
            #1 chk($sformatf("rst_read_a%0d", a), rd[0], 32'h0);
        end
        chipselect = 0;
        check_all("rst");

        wr(0, 32'hFFFF_FF3C);
        chk("wr_dout", 32'(op[0]), 32'h3C);
        wr(4, 32'h81);
        chk("set_bits", 32'(op[0]), 32'hBD);
        wr(5, 32'h0C);
        chk("clr_bits", 32'(op[0]), 32'hB1);
        address = 4; chipselect = 1;
        #1 chk("read_a4", rd[0], 32'h0);
        chipselect = 0;
        check_all("setclr");

        wr(2, 32'h01);
        in_port = 8'h01;
        address = 3;
        cyc();
        chk("edge_lat1", rd[0], 32'h0);
        cyc();
        chk("edge_lat2", rd[0], 32'h0);
        chk("lvl_irq_mode1", 32'(irqv[1]), 32'h1);
        cyc();
        chk("edge_lat3", rd[0], 32'h1);
        chk("edge_irq", 32'(irqv[0]), 32'h1);
        check_all("edge");
        wr(3, 32'h01);
        address = 3;
        #1 chk("w1c_clear", rd[0], 32'h0);
        chk("w1c_irq", 32'(irqv[0]), 32'h0);

        in_port = 8'h00;
        repeat (3) cyc();
        wr(3, 32'hFF);
        in_port = 8'h01;
        cyc();
        cyc();
        wr(3, 32'h01);
        address = 3;
        #1 chk("w1c_race", 32'(rd[0][0]), 32'h1);
        check_all("race");

        in_port = 8'hFF;
        do_reset();
        address = 3;
        for (int n = 0; n < 20; n++) begin
            #1 chk($sformatf("warm_ec0_%0d", n), rd[0], 32'h0);
            chk($sformatf("warm_ec1_%0d", n), rd[1], 32'h0);
            cyc();
        end

        in_port = 8'h00;
        repeat (3) cyc();
        wr(2, 32'h80);
        in_port = 8'h80;
        cyc();
        chk("lvl_rise1", 32'(irqv[1]), 32'h0);
        cyc();
        chk("lvl_rise2", 32'(irqv[1]), 32'h1);
        in_port = 8'h00;
        cyc();
        chk("lvl_fall1", 32'(irqv[1]), 32'h1);
        cyc();
        chk("lvl_fall2", 32'(irqv[1]), 32'h0);
        check_all("lvl");

        address = 1; chipselect = 1; write_n = 0; writedata = 32'hFF;
        #2 reset_n = 0;
        model_reset();
        #1;
        chk("midrst_out", 32'(op[0]), 32'hA5);
        chk("midrst_oe", 32'(oev[0]), 32'h0);
        repeat (2) @(posedge clk);
        #1 chipselect = 0; write_n = 1;
        reset_n = 1;
        #1 chk("midrst_wr_dropped", rd[1], 32'h0);
        check_all("midrst");

        for (int n = 0; n < 400; n++) begin
            address = 3'($urandom_range(0, 7));
            chipselect = ($urandom % 4) != 0;
            write_n = ($urandom % 3) != 0;
            writedata = $urandom;
            if ($urandom % 3 == 0) in_port = 8'($urandom);
            #1 check_all("rand");
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/avalon_pio_bidir.md
Name: avalon_pio_bidir

Overview:
Parametrised Avalon-MM slave parallel I/O port, the successor to the fixed 8-bit output-only PIO. Provides per-bit direction control, atomic set/clear of output bits, synchronised input sampling, per-bit edge capture and a maskable interrupt. Sits on the Nios II data master interconnect and drives or samples FPGA pins through `out_port`/`oe`/`in_port`.

Parameters:
- DATA_WIDTH, 8, number of I/O bits (1..32).
- RESET_VALUE, 0, `data_out` value after reset (DATA_WIDTH bits).
- EDGE_TYPE, 0, captured edge: 0 rising, 1 falling, 2 any.
- IRQ_MODE, 0, 0 = irq from `edgecapture & irqmask`; 1 = irq from `in_sync & irqmask` (level).

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `reset_n`  input  1  asynchronous active-low reset.
- `address`  input  3  word address of register.
- `chipselect`  input  1  slave select.
- `write_n`  input  1  active-low write strobe.
- `writedata`  input  32  write data.
- `readdata`  output  32  read data, combinational from `address` and registers.
- `in_port`  input  DATA_WIDTH  asynchronous pin inputs.
- `out_port`  output  DATA_WIDTH  `data_out` register.
- `oe`  output  DATA_WIDTH  `direction` register; 1 = bit driven.
- `irq`  output  1  interrupt request, active high.

Behaviour:
- Write occurs on a `clk` edge when `chipselect` is 1, `write_n` is 0 and `address` is valid. Otherwise no register changes.
- `writedata` bits at or above DATA_WIDTH are ignored. Unused `readdata` bits read 0.
- Register map (`address`, read / write):
  - 0: read `in_sync` / write `data_out`.
  - 1: read/write `direction`.
  - 2: read/write `irqmask`.
  - 3: read `edgecapture` / write-1-to-clear `edgecapture`.
  - 4: read 0 / write `data_out |= writedata`.
  - 5: read 0 / write `data_out &= ~writedata`.
  - 6, 7: read 0 / writes ignored.
- `readdata` is valid in the same cycle as `address` (0 wait states, 0 read latency). Reads have no side effects.
- Writing `data_out` is independent of `direction`. Bits with `oe` = 0 still hold the written value.
- Input path:
  - Two-flop synchroniser `in_port` -> `s1` -> `in_sync`, then `prev` <= `in_sync`.
  - Per-bit edge: rise = `in_sync & ~prev`; fall = `~in_sync & prev`; any = `in_sync ^ prev`.
  - A detected edge sets the `edgecapture` bit on the same clock that `prev` updates.
  - Latency from `in_port` change to `edgecapture` set is 3 clocks; to `in_sync` visible at address 0 is 2 clocks.
- Edge capture applies to all bits regardless of `direction`.
- Warm-up: a 2-bit counter counts from 0 to 3 after reset, then saturates. Edge capture is suppressed while the count is below 3, so a pin held high through reset release creates no spurious edge.
- Simultaneous W1C of `edgecapture` and a new edge on the same bit: set wins, the bit stays 1.
- `irq` = OR-reduce(`edgecapture & irqmask`) when IRQ_MODE = 0, or OR-reduce(`in_sync & irqmask`) when IRQ_MODE = 1. It is combinational from registers and asserts in the cycle after the capturing edge.
- Reset (asynchronous, any time, including mid-access):
  - `data_out` = RESET_VALUE.
  - `direction`, `irqmask`, `edgecapture`, `s1`, `in_sync`, `prev` and the warm-up counter = 0.
  - `irq` = 0, `oe` = 0.
  - An in-flight write is discarded.

Test Plan:
- DATA_WIDTH=8, RESET_VALUE=8'hA5: release reset -> `out_port`=8'hA5, `oe`=0, `irq`=0; read addr 1,2,3 -> 0.
- Write addr0 = 32'hFFFF_FF3C -> `out_port`=8'h3C. Write addr4 = 8'h81 -> 8'hBD. Write addr5 = 8'h0C -> 8'hB1. Read addr4 -> 0.
- EDGE_TYPE=0, `irqmask`=8'h01: drive `in_port[0]` 0->1 -> `edgecapture`=8'h01 exactly 3 clocks later, `irq`=1. Write addr3 = 8'h01 -> `edgecapture`=0, `irq`=0.
- W1C of bit 0 in the same cycle the detected edge sets bit 0 -> `edgecapture[0]` stays 1.
- `in_port`=8'hFF held through reset release -> `edgecapture` remains 0 for 20 clocks.
- IRQ_MODE=1, `irqmask`=8'h80, `in_port[7]`=1 -> `irq`=1 after 2 clocks, drops 2 clocks after `in_port[7]`=0. Assert `reset_n` mid-write -> all registers at reset values, write not applied.
